// File: rtl/dbus_dmem_resp.sv
// Data-bus responder: word-organised RAM serving LSU load/store requests.
// Latency: ack in cycle WAIT_STATES+1 after the request is first seen.
// Backpressure: request is level-held by the LSU until ack; no credits, one access in flight.

package dbus_pkg;

    typedef enum logic [1:0] {
        ST_OPS_NONE = 2'd0,
        ST_OPS_SB   = 2'd1,
        ST_OPS_SH   = 2'd2,
        ST_OPS_SW   = 2'd3
    } type_st_ops_e;

    typedef struct packed {
        logic [31:0]  addr;
        logic         ld_req;
        logic         st_req;
        logic [31:0]  w_data;
        type_st_ops_e st_ops;
    } type_lsu2dbus_s;

    typedef struct packed {
        logic [31:0] r_data;
        logic        ack;
    } type_dbus2lsu_s;

endpackage

module dbus_dmem_resp
    import dbus_pkg::*;
#(
    parameter int DEPTH_WORDS = 4096,
    parameter int WAIT_STATES = 1
) (
    input  logic           clk,
    input  logic           rst_n,        // synchronous, active-high despite the name
    input  type_lsu2dbus_s lsu2dbus_i,
    output type_dbus2lsu_s dbus2lsu_o,
    input  logic           lsu_flush_i,
    output logic           busy_o
);

    localparam int         AW      = $clog2(DEPTH_WORDS);
    localparam bit         NO_WAIT = (WAIT_STATES == 0);
    localparam logic [3:0] WS_INIT = 4'((WAIT_STATES > 0) ? (WAIT_STATES - 1) : 0);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    logic [1:0]    state;
    logic [3:0]    cnt;
    logic          ack_q;
    logic [31:0]   r_data_q;
    logic [31:0]   ram [DEPTH_WORDS];

    logic          req;
    logic [AW-1:0] idx;
    logic [3:0]    be;
    logic [31:0]   lane_data;
    logic          do_access;
    logic          wr_en;

    assign req = lsu2dbus_i.ld_req | lsu2dbus_i.st_req;
    assign idx = lsu2dbus_i.addr[AW+1:2];

    // Upper address bits are dropped on purpose: the RAM aliases modulo its size.
    logic unused_addr_bits;
    assign unused_addr_bits = ^lsu2dbus_i.addr[31:AW+2];

    // The access edge: either straight from idle (no wait states) or at the end of the wait count.
    assign do_access = req & ~lsu_flush_i &
                       (((state == ST_IDLE) & NO_WAIT) |
                        ((state == ST_WAIT) & (cnt == 4'd0)));

    // A reset edge that coincides with the access edge must not commit the store.
    assign wr_en = do_access & lsu2dbus_i.st_req & ~rst_n;

    // Byte enables and lane-replicated store data; misaligned halfword/word stores write nothing.
    always_comb begin
        be        = 4'b0000;
        lane_data = lsu2dbus_i.w_data;
        case (lsu2dbus_i.st_ops)
            ST_OPS_SB: begin
                be        = 4'b0001 << lsu2dbus_i.addr[1:0];
                lane_data = {4{lsu2dbus_i.w_data[7:0]}};
            end
            ST_OPS_SH: begin
                if (!lsu2dbus_i.addr[0]) begin
                    be = lsu2dbus_i.addr[1] ? 4'b1100 : 4'b0011;
                end
                lane_data = {2{lsu2dbus_i.w_data[15:0]}};
            end
            ST_OPS_SW: begin
                if (lsu2dbus_i.addr[1:0] == 2'b00) begin
                    be = 4'b1111;
                end
            end
            default: be = 4'b0000;
        endcase
    end

    // Control FSM plus registered response; r_data samples the pre-write word.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state    <= ST_IDLE;
            cnt      <= 4'd0;
            ack_q    <= 1'b0;
            r_data_q <= 32'd0;
        end else begin
            ack_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req && !lsu_flush_i) begin
                        if (NO_WAIT) begin
                            state <= ST_RESP;
                        end else begin
                            cnt   <= WS_INIT;
                            state <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (lsu_flush_i || !req) begin
                        state <= ST_IDLE;
                    end else if (cnt == 4'd0) begin
                        state <= ST_RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                ST_RESP: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
            if (do_access) begin
                r_data_q <= ram[idx];
                ack_q    <= 1'b1;
            end
        end
    end

    // RAM byte-lane writes; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (wr_en && be[b]) begin
                ram[idx][8*b +: 8] <= lane_data[8*b +: 8];
            end
        end
    end

    assign dbus2lsu_o.ack    = ack_q;
    assign dbus2lsu_o.r_data = r_data_q;
    assign busy_o            = (state == ST_WAIT) | (state == ST_RESP);

endmodule

// File: tb/tb_dbus_dmem_resp.sv
// Directed bench for dbus_dmem_resp: one instance with 1 wait state, one with 3.
// Expected read words are queued when a request is driven and popped on ack.
// All waits are bounded; a missing ack counts as a failure.

module tb_dbus_dmem_resp;
    import dbus_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst;
    type_lsu2dbus_s req_a, req_b;
    type_dbus2lsu_s rsp_a, rsp_b;
    logic           flush_a, flush_b, busy_a, busy_b;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] exp_q[$];

    dbus_dmem_resp #(.DEPTH_WORDS(4096), .WAIT_STATES(1)) u_a (
        .clk(clk), .rst_n(rst), .lsu2dbus_i(req_a), .dbus2lsu_o(rsp_a),
        .lsu_flush_i(flush_a), .busy_o(busy_a)
    );

    dbus_dmem_resp #(.DEPTH_WORDS(4096), .WAIT_STATES(3)) u_b (
        .clk(clk), .rst_n(rst), .lsu2dbus_i(req_b), .dbus2lsu_o(rsp_b),
        .lsu_flush_i(flush_b), .busy_o(busy_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // One full request/ack handshake on instance b (0: 1 wait state, 1: 3 wait states).
    task automatic access(input bit b, input bit ld, input bit st, input type_st_ops_e ops,
                          input logic [31:0] a, input logic [31:0] wd, input bit chk,
                          input logic [31:0] exp, input bit flush_at_ack, input string tag);
        type_lsu2dbus_s r;
        int             lat;
        int             ws;
        logic           got;
        logic           bsy;
        logic [31:0]    obs;
        logic [31:0]    e;
        ws = b ? 3 : 1;
        r  = '{addr: a, ld_req: ld, st_req: st, w_data: wd, st_ops: ops};
        if (chk) exp_q.push_back(exp);
        if (b) req_b = r; else req_a = r;
        got = 1'b0;
        lat = 0;
        while (!got && lat < 40) begin
            @(posedge clk); #1;
            lat++;
            got = b ? rsp_b.ack : rsp_a.ack;
            bsy = b ? busy_b : busy_a;
            check({tag, "_busy"}, {31'd0, bsy}, 32'd1);
        end
        check({tag, "_lat"}, 32'(lat), 32'(ws + 1));
        if (chk) begin
            e   = exp_q.pop_front();
            obs = b ? rsp_b.r_data : rsp_a.r_data;
            if (got) check({tag, "_rdata"}, obs, e);
        end
        if (flush_at_ack) begin
            if (b) flush_b = 1'b1; else flush_a = 1'b1;
        end
        if (b) req_b = '0; else req_a = '0;
        @(posedge clk); #1;
        got = b ? rsp_b.ack : rsp_a.ack;
        bsy = b ? busy_b : busy_a;
        check({tag, "_ack_single"}, {31'd0, got}, 32'd0);
        check({tag, "_idle"}, {31'd0, bsy}, 32'd0);
        flush_a = 1'b0;
        flush_b = 1'b0;
    endtask

    initial begin
        int acks;
        rst     = 1'b1;
        req_a   = '0;
        req_b   = '0;
        flush_a = 1'b0;
        flush_b = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ack_a", {31'd0, rsp_a.ack}, 32'd0);
        check("rst_rdata_a", rsp_a.r_data, 32'd0);
        check("rst_busy_a", {31'd0, busy_a}, 32'd0);
        check("rst_ack_b", {31'd0, rsp_b.ack}, 32'd0);
        check("rst_busy_b", {31'd0, busy_b}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Basic store / load and partial stores on 1-wait-state instance.
        access(0, 0, 1, ST_OPS_SW,   32'h10,   32'hDEADBEEF, 0, 32'h0,        0, "sw10");
        access(0, 1, 0, ST_OPS_NONE, 32'h10,   32'h0,        1, 32'hDEADBEEF, 0, "lw10a");
        access(0, 0, 1, ST_OPS_SB,   32'h12,   32'hAAAAAA55, 1, 32'hDEADBEEF, 0, "sb12");
        access(0, 0, 1, ST_OPS_SH,   32'h10,   32'hFFFFA1B2, 1, 32'hDE55BEEF, 0, "sh10");
        access(0, 1, 0, ST_OPS_NONE, 32'h10,   32'h0,        1, 32'hDE55A1B2, 0, "lw10b");
        access(0, 0, 1, ST_OPS_SW,   32'h11,   32'h12345678, 1, 32'hDE55A1B2, 0, "sw11_mis");
        access(0, 1, 0, ST_OPS_NONE, 32'h10,   32'h0,        1, 32'hDE55A1B2, 0, "lw10c");
        // Combined load+store returns the old word and commits the new one.
        access(0, 0, 1, ST_OPS_SW,   32'h20,   32'h00000007, 0, 32'h0,        0, "sw20");
        access(0, 1, 1, ST_OPS_SW,   32'h20,   32'h00000001, 1, 32'h00000007, 0, "amo20");
        access(0, 1, 0, ST_OPS_NONE, 32'h20,   32'h0,        1, 32'h00000001, 0, "lw20");
        // Address wrap and upper-halfword store.
        access(0, 1, 0, ST_OPS_NONE, 32'h4010, 32'h0,        1, 32'hDE55A1B2, 0, "lw_wrap");
        access(0, 0, 1, ST_OPS_SH,   32'h12,   32'h00001234, 1, 32'hDE55A1B2, 0, "sh12");
        access(0, 1, 0, ST_OPS_SW,   32'h13,   32'h0,        1, 32'h1234A1B2, 0, "lw13_ops");

        // Reset while an SW is waiting: no write, no ack.
        req_a = '{addr: 32'h10, ld_req: 1'b0, st_req: 1'b1, w_data: 32'hFFFFFFFF, st_ops: ST_OPS_SW};
        @(posedge clk); #1;
        check("rstw_busy_pre", {31'd0, busy_a}, 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        check("rstw_ack", {31'd0, rsp_a.ack}, 32'd0);
        check("rstw_busy", {31'd0, busy_a}, 32'd0);
        check("rstw_rdata", rsp_a.r_data, 32'd0);
        rst   = 1'b0;
        req_a = '0;
        @(posedge clk); #1;
        access(0, 1, 0, ST_OPS_NONE, 32'h10,   32'h0,        1, 32'h1234A1B2, 0, "lw_after_rst");

        // 3-wait-state instance: flush in cycle 2 of a pending store.
        access(1, 0, 1, ST_OPS_SW,   32'h30,   32'hCAFEF00D, 0, 32'h0,        0, "b_sw30");
        req_b = '{addr: 32'h30, ld_req: 1'b0, st_req: 1'b1, w_data: 32'h11111111, st_ops: ST_OPS_SW};
        acks  = 0;
        @(posedge clk); #1;
        if (rsp_b.ack) acks++;
        @(posedge clk); #1;
        if (rsp_b.ack) acks++;
        flush_b = 1'b1;
        @(posedge clk); #1;
        if (rsp_b.ack) acks++;
        check("flush_idle_c3", {31'd0, busy_b}, 32'd0);
        req_b   = '0;
        flush_b = 1'b0;
        repeat (8) begin
            @(posedge clk); #1;
            if (rsp_b.ack) acks++;
        end
        check("flush_no_ack", 32'(acks), 32'd0);
        access(1, 1, 0, ST_OPS_NONE, 32'h30,   32'h0,        1, 32'hCAFEF00D, 0, "b_lw30a");
        // Flush during the ack cycle is too late to cancel.
        access(1, 0, 1, ST_OPS_SW,   32'h30,   32'h22222222, 1, 32'hCAFEF00D, 1, "b_sw_flushack");
        access(1, 1, 0, ST_OPS_NONE, 32'h30,   32'h0,        1, 32'h22222222, 0, "b_lw30b");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
